// File: rtl/mp_mgmt_arb.sv
// mp_mgmt_arb: round-robin arbiter for two masters sharing one management slave port.
// Define MGMT_ARB_TIMEOUT_EN to add the watchdog that self-completes stalled transactions.
module mp_mgmt_arb #(
   parameter int TO_CYC = 255
) (
   input  logic        clk,
   input  logic        sys_rst,
   input  logic        m0_req,
   input  logic        m0_rwn,
   input  logic [31:0] m0_adr,
   input  logic [1:0]  m0_wen,
   input  logic [31:0] m0_txd,
   input  logic        m1_req,
   input  logic        m1_rwn,
   input  logic [31:0] m1_adr,
   input  logic [1:0]  m1_wen,
   input  logic [31:0] m1_txd,
   output logic        m0_ack,
   output logic        m0_rxe,
   output logic [31:0] m0_rxd,
   output logic        m1_ack,
   output logic        m1_rxe,
   output logic [31:0] m1_rxd,
   output logic        s_req,
   output logic        s_rwn,
   output logic [31:0] s_adr,
   output logic [1:0]  s_wen,
   output logic [31:0] s_txd,
   input  logic        s_ack,
   input  logic        s_rxe,
   input  logic [31:0] s_rxd,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, CMD, RDW} state_t;
   state_t      state_q;
   logic        gnt_q, gnt_d, s_req_q, s_rwn_q;
   logic [31:0] s_adr_q, s_txd_q, rxd;
   logic [1:0]  s_wen_q;
   logic        exp_ev, to_ev, ack_ev, rxe_ev;

   if (TO_CYC < 1 || TO_CYC > 255) begin : g_bad_to
      $error("mp_mgmt_arb: TO_CYC must be 1..255");
   end

   // gnt_q doubles as last-grant; simultaneous requests go to the other master
   assign gnt_d  = (m0_req & m1_req) ? ~gnt_q : m1_req;
   assign exp_ev = (state_q == CMD && s_ack) || (state_q == RDW && s_rxe);
`ifdef MGMT_ARB_TIMEOUT_EN
   logic [7:0] wd_q;
   logic       err_q;
   assign to_ev = state_q != IDLE && wd_q == 8'(TO_CYC - 1) && !exp_ev;
   assign err   = err_q;
   always_ff @(posedge clk or posedge sys_rst)
      if (sys_rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= (state_q == IDLE || ack_ev || rxe_ev) ? 8'd0 : wd_q + 8'd1;
         err_q <= err_q | to_ev;
      end
`else
   assign to_ev = 1'b0;
   assign err   = 1'b0;
`endif
   assign ack_ev = state_q == CMD && (s_ack || to_ev);
   assign rxe_ev = state_q == RDW && (s_rxe || to_ev);
   assign rxd    = to_ev ? 32'hDEAD_BEEF : s_rxd;
   assign m0_ack = ack_ev & ~gnt_q;
   assign m1_ack = ack_ev & gnt_q;
   assign m0_rxe = rxe_ev & ~gnt_q;
   assign m1_rxe = rxe_ev & gnt_q;
   assign m0_rxd = gnt_q ? 32'd0 : rxd;
   assign m1_rxd = gnt_q ? rxd : 32'd0;
   assign s_req  = s_req_q;
   assign s_rwn  = s_rwn_q;
   assign s_adr  = s_adr_q;
   assign s_wen  = s_wen_q;
   assign s_txd  = s_txd_q;

   always_ff @(posedge clk or posedge sys_rst)
      if (sys_rst) begin
         state_q <= IDLE;
         gnt_q   <= 1'b1;
         s_req_q <= 1'b0;
         s_rwn_q <= 1'b1;
         s_adr_q <= '0;
         s_wen_q <= '0;
         s_txd_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (m0_req | m1_req) begin
               state_q <= CMD;
               gnt_q   <= gnt_d;
               s_req_q <= 1'b1;
               s_rwn_q <= gnt_d ? m1_rwn : m0_rwn;
               s_adr_q <= gnt_d ? m1_adr : m0_adr;
               s_wen_q <= gnt_d ? m1_wen : m0_wen;
               s_txd_q <= gnt_d ? m1_txd : m0_txd;
            end
            CMD: if (ack_ev) begin
               s_req_q <= 1'b0;
               state_q <= (s_rwn_q && !to_ev) ? RDW : IDLE;
            end
            RDW: if (rxe_ev) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_mp_mgmt_arb.sv
// tb_mp_mgmt_arb: directed self-checking bench for mp_mgmt_arb.
module tb_mp_mgmt_arb;
   logic        clk = 0, sys_rst = 1;
   logic        m0_req = 0, m0_rwn = 0, m1_req = 0, m1_rwn = 0;
   logic [31:0] m0_adr = 0, m0_txd = 0, m1_adr = 0, m1_txd = 0;
   logic [1:0]  m0_wen = 0, m1_wen = 0;
   logic        m0_ack, m0_rxe, m1_ack, m1_rxe;
   logic [31:0] m0_rxd, m1_rxd;
   logic        s_req, s_rwn, s_ack = 0, s_rxe = 0, err;
   logic [31:0] s_adr, s_txd, s_rxd = 0;
   logic [1:0]  s_wen;
   int          n_cmp = 0, n_bad = 0, c0 = 0, c1 = 0;

   mp_mgmt_arb #(.TO_CYC(16)) dut (
      .clk(clk), .sys_rst(sys_rst),
      .m0_req(m0_req), .m0_rwn(m0_rwn), .m0_adr(m0_adr), .m0_wen(m0_wen), .m0_txd(m0_txd),
      .m1_req(m1_req), .m1_rwn(m1_rwn), .m1_adr(m1_adr), .m1_wen(m1_wen), .m1_txd(m1_txd),
      .m0_ack(m0_ack), .m0_rxe(m0_rxe), .m0_rxd(m0_rxd),
      .m1_ack(m1_ack), .m1_rxe(m1_rxe), .m1_rxd(m1_rxd),
      .s_req(s_req), .s_rwn(s_rwn), .s_adr(s_adr), .s_wen(s_wen), .s_txd(s_txd),
      .s_ack(s_ack), .s_rxe(s_rxe), .s_rxd(s_rxd), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_rst_vals(input string tag);
      chk({tag, "_sreq"}, 32'(s_req), 0);
      chk({tag, "_srwn"}, 32'(s_rwn), 1);
      chk({tag, "_sadr"}, s_adr, 0);
      chk({tag, "_swen"}, 32'(s_wen), 0);
      chk({tag, "_stxd"}, s_txd, 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_acks"}, {30'd0, m0_ack, m1_ack}, 0);
   endtask

   task automatic do_reset();
      sys_rst = 1;
      tick();
      tick();
      sys_rst = 0;
   endtask

   initial begin
      tick();
      chk_rst_vals("rst");
      sys_rst = 0;
      // single m0 write, slave acks on the second CMD cycle
      m0_req = 1; m0_rwn = 0; m0_adr = 32'h10; m0_wen = 2'b11; m0_txd = 32'h1234;
      #1 chk("wr_no_comb_sreq", 32'(s_req), 0);
      tick();
      chk("wr_sreq", 32'(s_req), 1);
      chk("wr_sadr", s_adr, 32'h10);
      chk("wr_srwn", 32'(s_rwn), 0);
      chk("wr_stxd", s_txd, 32'h1234);
      chk("wr_swen", 32'(s_wen), 3);
      chk("wr_ack_early", 32'(m0_ack), 0);
      tick();
      s_ack = 1;
      #1 chk("wr_ack", {30'd0, m0_ack, m1_ack}, 32'b10);
      tick();
      s_ack = 0; m0_req = 0;
      #1 chk("wr_sreq_drop", 32'(s_req), 0);
      chk("wr_ack_single", 32'(m0_ack), 0);
      // simultaneous reads after reset: m0 first
      do_reset();
      m0_req = 1; m0_rwn = 1; m0_adr = 32'h100;
      m1_req = 1; m1_rwn = 1; m1_adr = 32'h200;
      tick();
      chk("rd_first_adr", s_adr, 32'h100);
      s_ack = 1;
      #1 chk("rd0_ack", {30'd0, m0_ack, m1_ack}, 32'b10);
      tick();
      s_ack = 0; m0_req = 0;
      s_rxe = 1; s_rxd = 32'hA5A5_A5A5;
      #1 chk("rd0_rxe", {30'd0, m0_rxe, m1_rxe}, 32'b10);
      chk("rd0_rxd", m0_rxd, 32'hA5A5_A5A5);
      chk("rd0_m1rxd", m1_rxd, 0);
      tick();
      s_rxe = 0;
      tick();
      chk("rd1_adr", s_adr, 32'h200);
      s_ack = 1;
      #1 chk("rd1_ack", {30'd0, m0_ack, m1_ack}, 32'b01);
      tick();
      s_ack = 0; m1_req = 0;
      s_rxe = 1; s_rxd = 32'h5A5A_5A5A;
      #1 chk("rd1_rxe", {30'd0, m0_rxe, m1_rxe}, 32'b01);
      chk("rd1_rxd", m1_rxd, 32'h5A5A_5A5A);
      chk("rd1_m0rxd", m0_rxd, 0);
      tick();
      s_rxe = 0;
      // continuous contention: 8 writes alternate starting with m0
      m0_req = 1; m0_rwn = 0; m0_adr = 32'hA0;
      m1_req = 1; m1_rwn = 0; m1_adr = 32'hB0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rr_adr", s_adr, (i % 2) ? 32'hB0 : 32'hA0);
         s_ack = 1;
         #1 chk("rr_ack", {30'd0, m0_ack, m1_ack}, (i % 2) ? 32'b01 : 32'b10);
         c0 += int'(m0_ack);
         c1 += int'(m1_ack);
         tick();
         s_ack = 0;
      end
      m0_req = 0; m1_req = 0;
      chk("rr_cnt0", 32'(c0), 4);
      chk("rr_cnt1", 32'(c1), 4);
      // reset while waiting for read data, then a late s_rxe
      tick();
      m0_req = 1; m0_rwn = 1; m0_adr = 32'h300;
      tick();
      s_ack = 1;
      tick();
      s_ack = 0; m0_req = 0;
      sys_rst = 1;
      #1 chk_rst_vals("abort");
      tick();
      sys_rst = 0;
      tick();
      s_rxe = 1; s_rxd = 32'h77;
      #1 chk("abort_rxe", {30'd0, m0_rxe, m1_rxe}, 0);
      chk("abort_m0rxd", m0_rxd, 0);
      chk("abort_sreq", 32'(s_req), 0);
      tick();
      // spurious handshakes in IDLE are ignored
      s_ack = 1;
      #1 chk("spur_rxe", {30'd0, m0_rxe, m1_rxe}, 0);
      chk("spur_ack", {30'd0, m0_ack, m1_ack}, 0);
      tick();
      s_rxe = 0; s_ack = 0;
      chk("spur_sreq", 32'(s_req), 0);
      m0_req = 1; m0_rwn = 0; m0_adr = 32'h44;
      tick();
      chk("spur_then_grant", {31'd0, s_req}, 1);
      chk("spur_then_adr", s_adr, 32'h44);
      s_ack = 1;
      tick();
      s_ack = 0; m0_req = 0;
`ifdef MGMT_ARB_TIMEOUT_EN
      // m1 read whose data never returns; watchdog fires on 16th RDW cycle
      m1_req = 1; m1_rwn = 1; m1_adr = 32'h55;
      tick();
      s_ack = 1;
      tick();
      s_ack = 0; m1_req = 0;
      repeat (15) begin
         chk("to_wait_rxe", 32'(m1_rxe), 0);
         tick();
      end
      chk("to_rxe", {30'd0, m0_rxe, m1_rxe}, 32'b01);
      chk("to_rxd", m1_rxd, 32'hDEAD_BEEF);
      tick();
      chk("to_err", 32'(err), 1);
      chk("to_rxe_single", 32'(m1_rxe), 0);
      tick();
      tick();
      chk("to_err_sticky", 32'(err), 1);
      do_reset();
      #1 chk("to_err_clr", 32'(err), 0);
`else
      chk("err_tied", 32'(err), 0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
